// File: rtl/axi_lite_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_master_if
//  Purpose  : Bundles the local command/response port and the AXI4-Lite
//             bus of the axi_lite_master initiator. The master modport is
//             the initiator's view; the slave modport is the view of
//             whatever sits on the other side (the slave block and the
//             command source).
//  Revision : 1.0 - initial release
// ============================================================================
interface axi_lite_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  // Local command port
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_wstrb;

  // Local response port
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_resp;

  // AXI4-Lite read address / read data
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  // AXI4-Lite write address / write data / write response
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
    output cmd_ready,
    output rsp_valid, rsp_write, rsp_rdata, rsp_resp,
    input  rsp_ready,
    output araddr, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready,
    output awaddr, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
    input  cmd_ready,
    input  rsp_valid, rsp_write, rsp_rdata, rsp_resp,
    output rsp_ready,
    input  araddr, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready,
    input  awaddr, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface
`default_nettype wire

// File: rtl/axi_lite_master.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_master
//  Purpose  : AXI4-Lite initiator. Turns single-beat read/write commands
//             from a valid/ready command port into AXI4-Lite transactions
//             and returns each completion on a valid/ready response port.
//             Exactly one transaction is in flight at any time.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_lite_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  wire logic          aclk,
  input  wire logic          areset_n,
  axi_lite_master_if.master  bus_if
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_WR   = 3'd3,
    ST_B    = 3'd4,
    ST_RSP  = 3'd5
  } state_t;

  state_t            state_q;

  // Read address channel
  logic [ADDR_W-1:0] araddr_q;
  logic              arvalid_q;
  logic              rready_q;

  // Write address / data channels, each with its own completion flag so the
  // two handshakes may land in any order
  logic [ADDR_W-1:0] awaddr_q;
  logic              awvalid_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              wvalid_q;
  logic              aw_done_q;
  logic              w_done_q;
  logic              bready_q;

  // Completion holding register
  logic              rsp_valid_q;
  logic              rsp_write_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [1:0]        rsp_resp_q;

  // Handshake strobes and the resulting "channel finished" view, which
  // already includes a handshake happening in the current cycle
  logic              w_aw_hs;
  logic              w_w_hs;
  logic              aw_done_d;
  logic              w_done_d;

  assign w_aw_hs   = awvalid_q & bus_if.awready;
  assign w_w_hs    = wvalid_q  & bus_if.wready;
  assign aw_done_d = aw_done_q | w_aw_hs;
  assign w_done_d  = w_done_q  | w_w_hs;

  // The command port is open only while idle
  assign bus_if.cmd_ready = (state_q == ST_IDLE);

  assign bus_if.araddr    = araddr_q;
  assign bus_if.arvalid   = arvalid_q;
  assign bus_if.rready    = rready_q;
  assign bus_if.awaddr    = awaddr_q;
  assign bus_if.awvalid   = awvalid_q;
  assign bus_if.wdata     = wdata_q;
  assign bus_if.wstrb     = wstrb_q;
  assign bus_if.wvalid    = wvalid_q;
  assign bus_if.bready    = bready_q;
  assign bus_if.rsp_valid = rsp_valid_q;
  assign bus_if.rsp_write = rsp_write_q;
  assign bus_if.rsp_rdata = rsp_rdata_q;
  assign bus_if.rsp_resp  = rsp_resp_q;

  // Transaction sequencer: every valid/ready output is a register that is
  // set or cleared together with the state change that owns it
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state_q     <= ST_IDLE;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus_if.cmd_valid) begin
            if (bus_if.cmd_write) begin
              awaddr_q  <= bus_if.cmd_addr;
              wdata_q   <= bus_if.cmd_wdata;
              wstrb_q   <= bus_if.cmd_wstrb;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= ST_WR;
            end else begin
              araddr_q  <= bus_if.cmd_addr;
              arvalid_q <= 1'b1;
              state_q   <= ST_AR;
            end
          end
        end

        ST_AR: begin
          if (bus_if.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_R;
          end
        end

        ST_R: begin
          if (bus_if.rvalid) begin
            rready_q    <= 1'b0;
            rsp_rdata_q <= bus_if.rdata;
            rsp_resp_q  <= bus_if.rresp;
            rsp_write_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RSP;
          end
        end

        ST_WR: begin
          if (w_aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (aw_done_d && w_done_d) begin
            bready_q <= 1'b1;
            state_q  <= ST_B;
          end
        end

        ST_B: begin
          if (bus_if.bvalid) begin
            bready_q    <= 1'b0;
            rsp_resp_q  <= bus_if.bresp;
            rsp_rdata_q <= '0;
            rsp_write_q <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RSP;
          end
        end

        ST_RSP: begin
          if (bus_if.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // A stalled valid must stay high with an unchanged payload
  a_ar_hold: assert property (@(posedge aclk)
    (areset_n && arvalid_q && !bus_if.arready)
      |=> (!areset_n || (arvalid_q && $stable(araddr_q))));
  a_aw_hold: assert property (@(posedge aclk)
    (areset_n && awvalid_q && !bus_if.awready)
      |=> (!areset_n || (awvalid_q && $stable(awaddr_q))));
  a_w_hold: assert property (@(posedge aclk)
    (areset_n && wvalid_q && !bus_if.wready)
      |=> (!areset_n || (wvalid_q && $stable(wdata_q) && $stable(wstrb_q))));
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_lite_master
//  Purpose  : Self-checking bench for axi_lite_master: a reactive AXI4-Lite
//             slave with configurable wait states, a word-array model of
//             the slave memory, a vector table, hand-written multi-cycle
//             sequences and randomised traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_master;

  logic aclk = 1'b0;
  logic areset_n = 1'b0;
  always #5 aclk = ~aclk;

  axi_lite_master_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  axi_lite_master #(.ADDR_W(32), .DATA_W(32)) u_dut (
    .aclk     (aclk),
    .areset_n (areset_n),
    .bus_if   (bus_if.master)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Slave configuration (wait states before ready/valid, response codes)
  int         ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [1:0] r_resp_cfg = 2'b00, b_resp_cfg = 2'b00;
  bit         noise = 1'b0;

  // Slave observations
  int          n_ar = 0, n_r = 0, n_aw = 0, n_w = 0, n_b = 0, n_err = 0;
  logic [31:0] last_araddr = '0, last_awaddr = '0;
  logic [31:0] slv_mem [16];
  logic [31:0] ref_mem [16];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          ard, rd, awd, wd, bd;
    logic [1:0]  resp;
    int          hold;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: byte-enabled word memory, indexed by word address bits
  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx;
    idx = int'(addr[5:2]);
    for (int k = 0; k < 4; k++)
      if (strb[k]) ref_mem[idx][8*k +: 8] = data[8*k +: 8];
  endtask

  // ---------------------------------------------------------------- slave
  initial begin : slave
    int ar_w, r_w, aw_w, w_w, b_w;
    bit ar_stall, aw_stall, w_stall, aw_hs_p, w_hs_p, aw_got, w_got;
    logic [31:0] ar_sav, aw_sav, aw_a, w_d, rd_addr;
    logic [35:0] w_sav;
    logic [3:0]  w_s;
    ar_w = 0; r_w = 0; aw_w = 0; w_w = 0; b_w = 0;
    ar_stall = 0; aw_stall = 0; w_stall = 0; aw_hs_p = 0; w_hs_p = 0;
    aw_got = 0; w_got = 0; ar_sav = '0; aw_sav = '0; w_sav = '0;
    aw_a = '0; w_d = '0; w_s = '0; rd_addr = '0;
    bus_if.arready = 0; bus_if.rvalid = 0; bus_if.rdata = '0; bus_if.rresp = '0;
    bus_if.awready = 0; bus_if.wready = 0; bus_if.bvalid = 0; bus_if.bresp = '0;
    forever begin
      @(posedge aclk); #1;
      if (!areset_n) begin
        ar_w = 0; r_w = 0; aw_w = 0; w_w = 0; b_w = 0;
        ar_stall = 0; aw_stall = 0; w_stall = 0; aw_hs_p = 0; w_hs_p = 0;
        aw_got = 0; w_got = 0;
        bus_if.arready = 0; bus_if.rvalid = 0; bus_if.awready = 0;
        bus_if.wready = 0; bus_if.bvalid = 0;
        continue;
      end
      // protocol watch
      if (ar_stall && (!bus_if.arvalid || bus_if.araddr !== ar_sav)) n_err++;
      if (aw_stall && (!bus_if.awvalid || bus_if.awaddr !== aw_sav)) n_err++;
      if (w_stall && (!bus_if.wvalid || {bus_if.wstrb, bus_if.wdata} !== w_sav)) n_err++;
      if (aw_hs_p && bus_if.awvalid) n_err++;
      if (w_hs_p && bus_if.wvalid) n_err++;
      if (bus_if.bready && !(aw_got && w_got)) n_err++;
      if (bus_if.rready && bus_if.arvalid) n_err++;
      if (bus_if.arvalid && (bus_if.awvalid || bus_if.wvalid)) n_err++;

      // AR
      bus_if.arready = 0;
      if (bus_if.arvalid) begin
        if (ar_w >= ar_dly) begin
          bus_if.arready = 1; ar_w = 0;
          n_ar++; last_araddr = bus_if.araddr; rd_addr = bus_if.araddr;
        end else ar_w++;
      end else ar_w = 0;
      ar_stall = bus_if.arvalid && !bus_if.arready;
      ar_sav   = bus_if.araddr;

      // R
      if (bus_if.rready) begin
        if (r_w >= r_dly) begin
          bus_if.rvalid = 1; bus_if.rdata = slv_mem[rd_addr[5:2]];
          bus_if.rresp = r_resp_cfg; n_r++; r_w = 0;
        end else begin
          bus_if.rvalid = 0; r_w++;
        end
      end else begin
        r_w = 0;
        bus_if.rvalid = noise ? 1'($urandom) : 1'b0;
        bus_if.rdata = $urandom; bus_if.rresp = 2'($urandom);
      end

      // AW
      bus_if.awready = 0; aw_hs_p = 0;
      if (bus_if.awvalid) begin
        if (aw_w >= aw_dly) begin
          bus_if.awready = 1; aw_w = 0; aw_hs_p = 1;
          n_aw++; last_awaddr = bus_if.awaddr; aw_a = bus_if.awaddr; aw_got = 1;
        end else aw_w++;
      end else aw_w = 0;
      aw_stall = bus_if.awvalid && !bus_if.awready;
      aw_sav   = bus_if.awaddr;

      // W
      bus_if.wready = 0; w_hs_p = 0;
      if (bus_if.wvalid) begin
        if (w_w >= w_dly) begin
          bus_if.wready = 1; w_w = 0; w_hs_p = 1;
          n_w++; w_d = bus_if.wdata; w_s = bus_if.wstrb; w_got = 1;
        end else w_w++;
      end else w_w = 0;
      w_stall = bus_if.wvalid && !bus_if.wready;
      w_sav   = {bus_if.wstrb, bus_if.wdata};

      // B
      if (bus_if.bready) begin
        if (b_w >= b_dly) begin
          bus_if.bvalid = 1; bus_if.bresp = b_resp_cfg; n_b++; b_w = 0;
          for (int k = 0; k < 4; k++)
            if (w_s[k]) slv_mem[aw_a[5:2]][8*k +: 8] = w_d[8*k +: 8];
          aw_got = 0; w_got = 0;
        end else begin
          bus_if.bvalid = 0; b_w++;
        end
      end else begin
        b_w = 0;
        bus_if.bvalid = noise ? 1'($urandom) : 1'b0;
        bus_if.bresp = 2'($urandom);
      end
    end
  end

  // One complete command/response exchange with expectation checks
  task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb,
                         input int ard, input int rd, input int awd, input int wd, input int bd,
                         input logic [1:0] resp, input int hold,
                         input logic [31:0] exp_rdata, input logic [1:0] exp_resp);
    int c_ar, c_r, c_aw, c_w, c_b, c_err, waited, busy;
    logic [34:0] snap;
    bit stable;
    ar_dly = ard; r_dly = rd; aw_dly = awd; w_dly = wd; b_dly = bd;
    r_resp_cfg = resp; b_resp_cfg = resp;
    c_ar = n_ar; c_r = n_r; c_aw = n_aw; c_w = n_w; c_b = n_b; c_err = n_err;
    waited = 0;
    while (!bus_if.cmd_ready && waited < 20) begin @(posedge aclk); #1; waited++; end
    check({tag, " idle"}, bus_if.cmd_ready, 1);
    bus_if.cmd_valid = 1; bus_if.cmd_write = wr; bus_if.cmd_addr = addr;
    bus_if.cmd_wdata = data; bus_if.cmd_wstrb = strb;
    @(posedge aclk); #1;
    bus_if.cmd_valid = 0; bus_if.cmd_write = 1'($urandom); bus_if.cmd_addr = $urandom;
    bus_if.cmd_wdata = $urandom; bus_if.cmd_wstrb = 4'($urandom);
    waited = 0; busy = 0;
    while (!bus_if.rsp_valid && waited < 200) begin
      if (bus_if.cmd_ready) busy++;
      @(posedge aclk); #1; waited++;
    end
    check({tag, " rsp_valid"}, bus_if.rsp_valid, 1);
    snap = {bus_if.rsp_write, bus_if.rsp_resp, bus_if.rsp_rdata};
    stable = 1;
    for (int h = 0; h < hold; h++) begin
      if (bus_if.cmd_ready) busy++;
      @(posedge aclk); #1;
      if (!bus_if.rsp_valid || {bus_if.rsp_write, bus_if.rsp_resp, bus_if.rsp_rdata} !== snap) stable = 0;
    end
    if (hold > 0) check({tag, " rsp held"}, stable, 1);
    check({tag, " busy cmd_ready"}, busy, 0);
    check({tag, " rsp_write"}, bus_if.rsp_write, wr);
    check({tag, " rsp_rdata"}, bus_if.rsp_rdata, exp_rdata);
    check({tag, " rsp_resp"}, bus_if.rsp_resp, exp_resp);
    bus_if.rsp_ready = 1;
    @(posedge aclk); #1;
    bus_if.rsp_ready = 0;
    check({tag, " rsp consumed"}, {bus_if.rsp_valid, bus_if.cmd_ready}, 2'b01);
    check({tag, " handshakes ar,r,aw,w,b"},
          {4'(n_ar - c_ar), 4'(n_r - c_r), 4'(n_aw - c_aw), 4'(n_w - c_w), 4'(n_b - c_b)},
          wr ? {4'd0, 4'd0, 4'd1, 4'd1, 4'd1} : {4'd1, 4'd1, 4'd0, 4'd0, 4'd0});
    check({tag, " bus addr"}, wr ? last_awaddr : last_araddr, addr);
    check({tag, " protocol errors"}, n_err - c_err, 0);
  endtask

  // ----------------------------------------------------------------- main
  initial begin : main
    int acc_n, cons_n, outst, viol, seen;
    logic        wr;
    logic [31:0] addr, data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    int          idx;

    // Vectors; expected values follow from an all-zero memory and table order
    vecs[0] = '{1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0,        2'b00};
    vecs[1] = '{1'b0, 32'h04, 32'h0,        4'h0, 3, 0, 0, 0, 0, 2'b00, 0, 32'hDEADBEEF, 2'b00};
    vecs[2] = '{1'b1, 32'h08, 32'h11223344, 4'h5, 0, 0, 2, 0, 0, 2'b00, 0, 32'h0,        2'b00};
    vecs[3] = '{1'b1, 32'h0C, 32'hCAFEF00D, 4'hF, 0, 0, 0, 2, 1, 2'b10, 0, 32'h0,        2'b10};
    vecs[4] = '{1'b1, 32'h10, 32'hA5A5A5A5, 4'h3, 0, 0, 1, 1, 0, 2'b11, 2, 32'h0,        2'b11};
    vecs[5] = '{1'b0, 32'h08, 32'h0,        4'h0, 0, 2, 0, 0, 0, 2'b00, 0, 32'h00220044, 2'b00};
    vecs[6] = '{1'b0, 32'h04, 32'h0,        4'h0, 1, 0, 0, 0, 0, 2'b10, 5, 32'hDEADBEEF, 2'b10};
    vecs[7] = '{1'b0, 32'h0C, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 0, 32'hCAFEF00D, 2'b00};
    vecs[8] = '{1'b0, 32'h10, 32'h0,        4'h0, 2, 1, 0, 0, 0, 2'b11, 1, 32'h0000A5A5, 2'b11};
    vecs[9] = '{1'b0, 32'h20, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0,        2'b00};

    for (int i = 0; i < 16; i++) begin slv_mem[i] = '0; ref_mem[i] = '0; end
    bus_if.cmd_valid = 0; bus_if.cmd_write = 0; bus_if.cmd_addr = '0;
    bus_if.cmd_wdata = '0; bus_if.cmd_wstrb = '0; bus_if.rsp_ready = 0;

    // Reset state
    areset_n = 0;
    repeat (3) @(posedge aclk);
    #1;
    check("reset valids", {bus_if.arvalid, bus_if.rready, bus_if.awvalid, bus_if.wvalid,
                           bus_if.bready, bus_if.rsp_valid}, 6'b0);
    check("reset cmd_ready", bus_if.cmd_ready, 1);
    check("reset addrs", {bus_if.araddr, bus_if.awaddr}, 64'h0);
    check("reset wdata/wstrb", {bus_if.wstrb, bus_if.wdata}, 36'h0);
    check("reset rsp fields", {bus_if.rsp_write, bus_if.rsp_resp, bus_if.rsp_rdata}, 35'h0);
    areset_n = 1;
    @(posedge aclk); #1;

    // Vector table
    for (int i = 0; i < 10; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb,
              vecs[i].ard, vecs[i].rd, vecs[i].awd, vecs[i].wd, vecs[i].bd,
              vecs[i].resp, vecs[i].hold, vecs[i].exp_rdata, vecs[i].exp_resp);
      if (vecs[i].wr) model_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
    end

    noise = 1'b1;

    // Minimum latency, write then read, zero-wait slave
    ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0;
    r_resp_cfg = 2'b00; b_resp_cfg = 2'b00;
    bus_if.cmd_valid = 1; bus_if.cmd_write = 1; bus_if.cmd_addr = 32'h14;
    bus_if.cmd_wdata = 32'h0BADCAFE; bus_if.cmd_wstrb = 4'hF;
    @(posedge aclk); #1;
    bus_if.cmd_valid = 0;
    check("lat wr N+1", {bus_if.awvalid, bus_if.wvalid, bus_if.bready, bus_if.cmd_ready}, 4'b1100);
    @(posedge aclk); #1;
    check("lat wr N+2", {bus_if.awvalid, bus_if.wvalid, bus_if.bready, bus_if.rsp_valid}, 4'b0010);
    @(posedge aclk); #1;
    check("lat wr N+3", {bus_if.rsp_valid, bus_if.rsp_write, bus_if.rsp_resp}, 4'b1100);
    bus_if.rsp_ready = 1;
    @(posedge aclk); #1;
    bus_if.rsp_ready = 0;
    model_write(32'h14, 32'h0BADCAFE, 4'hF);

    bus_if.cmd_valid = 1; bus_if.cmd_write = 0; bus_if.cmd_addr = 32'h14;
    @(posedge aclk); #1;
    bus_if.cmd_valid = 0;
    check("lat rd N+1", {bus_if.arvalid, bus_if.rready, bus_if.cmd_ready}, 3'b100);
    @(posedge aclk); #1;
    check("lat rd N+2", {bus_if.arvalid, bus_if.rready, bus_if.rsp_valid}, 3'b010);
    @(posedge aclk); #1;
    check("lat rd N+3", {bus_if.rsp_valid, bus_if.rsp_write}, 2'b10);
    check("lat rd rdata", bus_if.rsp_rdata, ref_mem[5]);
    bus_if.rsp_ready = 1;
    @(posedge aclk); #1;
    bus_if.rsp_ready = 0;

    // Back-to-back reads with cmd_valid held high
    acc_n = 0; cons_n = 0; outst = 0; viol = 0;
    bus_if.rsp_ready = 1;
    bus_if.cmd_valid = 1; bus_if.cmd_write = 0; bus_if.cmd_addr = 32'h04;
    for (int cyc = 0; cyc < 60 && cons_n < 3; cyc++) begin
      @(negedge aclk);
      if (bus_if.cmd_valid && bus_if.cmd_ready) begin acc_n++; outst++; end
      if (bus_if.rsp_valid && bus_if.rsp_ready) begin
        cons_n++; outst--;
        if (bus_if.cmd_valid && bus_if.cmd_ready) viol++;
        check("b2b rdata", bus_if.rsp_rdata, ref_mem[1]);
      end
      if (outst > 1) viol++;
      @(posedge aclk); #1;
      if (acc_n == 3) bus_if.cmd_valid = 0;
    end
    bus_if.cmd_valid = 0; bus_if.rsp_ready = 0;
    check("b2b accepted", acc_n, 3);
    check("b2b consumed", cons_n, 3);
    check("b2b overlap", viol, 0);

    // Randomised traffic against the memory model
    for (int t = 0; t < 40; t++) begin
      wr   = 1'($urandom);
      idx  = int'($urandom_range(0, 15));
      addr = ($urandom & 32'hFFFF_FFC0) | (32'(idx) << 2);
      data = $urandom;
      strb = 4'($urandom);
      resp = 2'($urandom);
      run_txn($sformatf("rnd%0d", t), wr, addr, data, strb,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), resp, int'($urandom_range(0, 3)),
              wr ? 32'h0 : ref_mem[idx], resp);
      if (wr) model_write(addr, data, strb);
    end

    // Reset while the write address is still stalled
    aw_dly = 10; w_dly = 0; b_dly = 0;
    bus_if.cmd_valid = 1; bus_if.cmd_write = 1; bus_if.cmd_addr = 32'h18;
    bus_if.cmd_wdata = 32'h12345678; bus_if.cmd_wstrb = 4'hF;
    @(posedge aclk); #1;
    bus_if.cmd_valid = 0;
    check("rst-wr N+1", {bus_if.awvalid, bus_if.wvalid}, 2'b11);
    @(posedge aclk); #1;
    check("rst-wr N+2", {bus_if.awvalid, bus_if.wvalid}, 2'b10);
    areset_n = 0;
    @(posedge aclk); #1;
    check("rst-wr after reset", {bus_if.arvalid, bus_if.rready, bus_if.awvalid, bus_if.wvalid,
                                 bus_if.bready, bus_if.rsp_valid, bus_if.cmd_ready}, 7'b0000001);
    repeat (2) @(posedge aclk);
    #1;
    areset_n = 1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge aclk); #1;
      if (bus_if.rsp_valid) seen++;
    end
    check("rst-wr no completion", seen, 0);
    run_txn("post-reset rd", 1'b0, 32'h18, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 0,
            ref_mem[6], 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached (passed %0d of %0d)", n_pass, n_total);
    $fatal(1);
  end

endmodule
`default_nettype wire
